// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmit path and the keyboard
// receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;
  localparam logic [3:0] PS2_FRAME_EDGES = 4'd11;

  // Bit positions inside the LED mask byte that follows PS2_CMD_SET_LED.
  localparam int unsigned PS2_LED_SCROLL = 0;
  localparam int unsigned PS2_LED_NUM    = 1;
  localparam int unsigned PS2_LED_CAPS   = 2;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the raw PS/2 clock and data lines plus a registered
// falling-edge pulse on the clock line, aligned with sync_clk going low.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic sync_clk,
  output logic sync_data,
  output logic clk_fall
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_fall_q, clk_fall_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    // Stage 1 already low while stage 2 is still high: sync_clk falls this edge.
    clk_fall_d  = clk_sync_q[1] & ~clk_sync_q[0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_fall_q  <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_fall_q  <= clk_fall_d;
    end
  end

  assign sync_clk  = clk_sync_q[1];
  assign sync_data = data_sync_q[1];
  assign clk_fall  = clk_fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter with device ACK/NACK reporting.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a stalled transfer.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  // The REQ entry cycle still pulls the clock low, so INHIBIT ends one early.
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 2);

  if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic sync_clk, sync_data, clk_fall;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .sync_clk   (sync_clk),
    .sync_data  (sync_data),
    .clk_fall   (clk_fall)
  );

  ps2_tx_state_e    state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             tx_ready_q, tx_ready_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             timeout_q, timeout_d;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bitcnt_d   = bitcnt_q;
    inh_cnt_d  = inh_cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    tx_ready_d = tx_ready_q;
    ack_err_d  = ack_err_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d       = wd_q;
`endif

    case (state_q)
      IDLE: begin
        tx_ready_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          shift_d    = tx_data;
          parity_d   = odd_parity(tx_data);
          inh_cnt_d  = '0;
          clk_oe_d   = 1'b1;
          data_oe_d  = 1'b0;
          tx_ready_d = 1'b0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          bitcnt_d  = 4'd0;
          state_d   = REQ;
`ifdef PS2_TX_TIMEOUT_EN
          wd_d      = '0;
`endif
        end
      end
      REQ: begin
        clk_oe_d = 1'b0;
        if (clk_fall) begin
          bitcnt_d  = 4'd1;
          data_oe_d = ~shift_q[0];
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q < 4'd8) begin
            data_oe_d = ~shift_q[bitcnt_q[2:0]];
          end else if (bitcnt_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          bitcnt_d  = PS2_FRAME_EDGES;
          ack_err_d = sync_data;
          state_d   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (sync_clk && sync_data) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    if (state_q inside {REQ, SHIFT, ACK}) begin
      wd_d = wd_q + 1'b1;
      if (wd_q == WD_LAST) begin
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        tx_ready_d = 1'b0;
        done_d     = 1'b1;
        ack_err_d  = 1'b1;
        timeout_d  = 1'b1;
        state_d    = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bitcnt_q   <= '0;
      inh_cnt_q  <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bitcnt_q   <= bitcnt_d;
      inh_cnt_q  <= inh_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      timeout_q  <= timeout_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural keyboard clocks frames out of
// the DUT over wired-AND lines and reports the bits it sampled.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TMO  = 2000;
  localparam int HALF = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       dev_clk, dev_data;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       done, ack_err, timeout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .done       (done),
    .ack_err    (ack_err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL accept_ready_drop: tx_ready=%b expected 0", tx_ready);
    end
  endtask

  task automatic dev_pulse();
    dev_clk = 1'b0; repeat (HALF) @(negedge clk);
    dev_clk = 1'b1; repeat (HALF) @(negedge clk);
  endtask

  // Keyboard model: measures the inhibit, clocks 11 edges, samples on rises.
  task automatic run_frame(input bit ack, output logic [10:0] bits, output int inh_len);
    int guard;
    guard = 0; inh_len = 0; bits = '0;
    while (ps2_clk_oe !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    while (ps2_clk_oe === 1'b1 && inh_len < 4 * INH) begin inh_len++; @(negedge clk); end
    bits[0] = ps2_data_in;
    repeat (4) @(negedge clk);
    for (int e = 1; e <= 10; e++) begin
      dev_clk = 1'b0; repeat (HALF) @(negedge clk);
      bits[e] = ps2_data_in;
      dev_clk = 1'b1; repeat (HALF) @(negedge clk);
    end
    dev_data = ack ? 1'b0 : 1'b1;
    dev_clk = 1'b0; repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    if (ack) begin
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input string name, output bit got);
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    got = (done === 1'b1);
    checks++;
    if (!got) begin errors++; $display("FAIL %s_done: no done pulse within 100 cycles", name); end
  endtask

  task automatic do_frame(input string name, input logic [7:0] d, input bit ack,
                          input logic [10:0] exp_bits, input logic exp_err, output int inh);
    logic [10:0] bits;
    bit got;
    start_tx(d);
    run_frame(ack, bits, inh);
    checks++;
    if (bits !== exp_bits) begin
      errors++; $display("FAIL %s_bits: got %b expected %b", name, bits, exp_bits);
    end
    wait_done(name, got);
    checks++;
    if (ack_err !== exp_err) begin
      errors++; $display("FAIL %s_ack_err: got %b expected %b", name, ack_err, exp_err);
    end
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL %s_ready_at_done: got %b expected 0", name, tx_ready);
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL %s_after_done: tx_ready=%b done=%b expected 1/0", name, tx_ready, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_ready, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_state: ready/clk_oe/data_oe/done/ack_err/timeout=%b%b%b%b%b%b expected 100000",
               tx_ready, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout);
    end
  endtask

  task automatic test_cmd_ed();
    int inh;
    // 0xED LSB first 1,0,1,1,0,1,1,1; six ones -> parity 1; stop 1; start 0.
    do_frame("cmd_ed", 8'hED, 1'b1, 11'b1_1_11101101_0, 1'b0, inh);
    checks++;
    if (inh != INH) begin errors++; $display("FAIL cmd_ed_inhibit: got %0d cycles expected %0d", inh, INH); end
  endtask

  task automatic test_parity();
    int inh;
    do_frame("parity_01", 8'h01, 1'b1, 11'b1_0_00000001_0, 1'b0, inh);
    do_frame("parity_00", 8'h00, 1'b1, 11'b1_1_00000000_0, 1'b0, inh);
  endtask

  task automatic test_nack();
    int inh;
    do_frame("nack_f4", 8'hF4, 1'b0, 11'b1_0_11110100_0, 1'b1, inh);
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    int inh, base, oe_cycles;
    bit got;
    base = done_cnt;
    tx_data = 8'hED; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h04;
    run_frame(1'b1, bits, inh);
    checks++;
    if (bits !== 11'b1_1_11101101_0) begin
      errors++; $display("FAIL b2b_first_bits: got %b expected %b", bits, 11'b1_1_11101101_0);
    end
    wait_done("b2b_first", got);
    checks++;
    if (ps2_clk_oe !== 1'b0) begin
      errors++; $display("FAIL b2b_inhibit_early: clk_oe=%b at first done expected 0", ps2_clk_oe);
    end
    run_frame(1'b1, bits, inh);
    checks++;
    if (bits !== 11'b1_0_00000100_0) begin
      errors++; $display("FAIL b2b_second_bits: got %b expected %b", bits, 11'b1_0_00000100_0);
    end
    wait_done("b2b_second", got);
    tx_valid = 1'b0;
    oe_cycles = 0;
    repeat (2 * INH) begin @(negedge clk); if (ps2_clk_oe === 1'b1) oe_cycles++; end
    checks++;
    if (oe_cycles != 0 || done_cnt - base != 2) begin
      errors++; $display("FAIL b2b_frame_count: frames=%0d extra_inhibit=%0d expected 2/0",
                         done_cnt - base, oe_cycles);
    end
  endtask

  task automatic test_reset_mid_shift();
    int guard, base;
    base = done_cnt;
    start_tx(8'hA5);
    guard = 0;
    while (ps2_clk_oe === 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    repeat (4) @(negedge clk);
    dev_pulse();
    dev_pulse();
    checks++;
    if (ps2_data_oe !== 1'b1) begin
      errors++; $display("FAIL mid_shift_bit1: data_oe=%b expected 1", ps2_data_oe);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL mid_reset_oe: clk_oe=%b data_oe=%b expected 0/0", ps2_clk_oe, ps2_data_oe);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: clk_oe=%b data_oe=%b tx_ready=%b expected 0/0/1",
                         ps2_clk_oe, ps2_data_oe, tx_ready);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != base) begin
      errors++; $display("FAIL mid_reset_no_done: got %0d done pulses expected 0", done_cnt - base);
    end
  endtask

  task automatic test_no_device_clock();
    int guard, i, base;
    base = done_cnt;
    start_tx(8'hED);
    guard = 0;
    while (ps2_data_oe !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    i = 0;
`ifdef PS2_TX_TIMEOUT_EN
    while (timeout !== 1'b1 && i < TMO + 100) begin @(negedge clk); i++; end
    checks++;
    if (i != TMO) begin errors++; $display("FAIL timeout_cycle: got %0d expected %0d", i, TMO); end
    checks++;
    if ({done, ack_err, ps2_clk_oe, ps2_data_oe} !== 4'b1100) begin
      errors++; $display("FAIL timeout_outputs: done/ack_err/clk_oe/data_oe=%b%b%b%b expected 1100",
                         done, ack_err, ps2_clk_oe, ps2_data_oe);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_after: timeout=%b tx_ready=%b expected 0/1", timeout, tx_ready);
    end
`else
    repeat (TMO + 500) @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, timeout} !== 4'b0100 || done_cnt != base) begin
      errors++; $display("FAIL stuck_in_req: clk_oe/data_oe/ready/timeout=%b%b%b%b dones=%0d expected 0100/0",
                         ps2_clk_oe, ps2_data_oe, tx_ready, timeout, done_cnt - base);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL stuck_recover: tx_ready=%b data_oe=%b expected 1/0", tx_ready, ps2_data_oe);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
    dev_clk = 1'b1; dev_data = 1'b1;
    @(negedge clk);
    test_reset();
    test_cmd_ed();
    test_parity();
    test_nack();
    test_back_to_back();
    test_reset_mid_shift();
    test_no_device_clock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
